m_axis_tx_fifo: RTL and testbench

- AXI4-Stream master transmitter. It is the output-side counterpart of the slave-side input FIFO.
- Accepts the push-only result stream produced by the psum/pool output packers (valid/data/last, no backpressure) and buffers it.
- Drives M_AXIS_TVALID/TDATA/TSTRB/TLAST toward the DMA while honouring TREADY backpressure.
- Reports FIFO occupancy, overflow and frame completion to the controller.

---
 rtl/m_axis_tx_fifo.sv | 179 +++++++++++++++++
 tb/tb_m_axis_tx_fifo.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_axis_tx_fifo.sv
// ---------------------------------------------------------------------------
// m_axis_tx_fifo
//   AXI4-Stream master transmitter. Buffers the push-only result stream from
//   the output packers in a small FIFO and launches it onto the AXI-Stream
//   bus through a single output register, honouring TREADY backpressure.
//
// Ports
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   in_valid/data/last  : push interface from the packer (no backpressure)
//   axis_en             : allows new beats to be launched onto the bus
//   axis_clear          : flushes storage, pointers and the overflow flag
//   M_AXIS_*            : AXI-Stream master (TSTRB tied to all ones)
//   fifo_full/almost_full/empty : registered storage-occupancy flags
//   overflow            : sticky, a push was dropped while full
//   frame_done          : one-cycle pulse after a TLAST handshake
//   beat_cnt            : handshakes in the current frame (saturating)
// ---------------------------------------------------------------------------
module m_axis_tx_fifo #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH           = 16,
    parameter int ADDR_WIDTH           = 4,
    parameter int ALMOST_FULL_MARGIN   = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   in_data,
    input  logic                              in_last,
    input  logic                              axis_en,
    input  logic                              axis_clear,
    output logic                              M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
    output logic                              M_AXIS_TLAST,
    input  logic                              M_AXIS_TREADY,
    output logic                              fifo_full,
    output logic                              fifo_almost_full,
    output logic                              fifo_empty,
    output logic                              overflow,
    output logic                              frame_done,
    output logic [15:0]                       beat_cnt
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] MARGIN_C = CNT_W'(ALMOST_FULL_MARGIN);

    // The output register's valid bit is the state itself.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_VALID = 1'b1
    } out_state_t;

    // Storage entries hold {last, data}.
    logic [C_M_AXIS_TDATA_WIDTH:0] r_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]         r_wr_ptr;
    logic [ADDR_WIDTH-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]              r_count;
    out_state_t                    r_state;

    out_state_t                    w_state_next;
    logic                          w_handshake;
    logic                          w_can_pop;
    logic                          w_pop;
    logic                          w_push;
    logic                          w_drop;
    logic [CNT_W-1:0]              w_count_next;
    logic [C_M_AXIS_TDATA_WIDTH:0] w_head;

    assign w_head        = r_mem[r_rd_ptr];
    assign M_AXIS_TVALID = (r_state == OUT_VALID);
    assign M_AXIS_TSTRB  = '1;

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_handshake  = (r_state == OUT_VALID) && M_AXIS_TREADY;
        // A clear flushes the head too, so nothing is popped that cycle.
        w_can_pop    = axis_en && (r_count != '0) && !axis_clear;

        case (r_state)
            OUT_EMPTY: begin
                if (w_can_pop) begin
                    w_pop        = 1'b1;
                    w_state_next = OUT_VALID;
                end
            end
            OUT_VALID: begin
                // Without a handshake the presented beat is held unchanged.
                if (M_AXIS_TREADY) begin
                    if (w_can_pop) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_next = OUT_EMPTY;
                    end
                end
            end
            default: w_state_next = OUT_EMPTY;
        endcase

        // A same-cycle pop frees a slot, so a full FIFO can still accept.
        w_push = in_valid && !axis_clear && ((r_count != DEPTH_C) || w_pop);
        w_drop = in_valid && !axis_clear && !w_push;

        w_count_next = r_count;
        if (axis_clear) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; pointers and count
    // define which entries are meaningful, and a resettable array would cost
    // a reset net on every bit.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_last, in_data};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_state          <= OUT_EMPTY;
            M_AXIS_TDATA     <= '0;
            M_AXIS_TLAST     <= 1'b0;
            fifo_full        <= 1'b0;
            fifo_almost_full <= 1'b0;
            fifo_empty       <= 1'b1;
            overflow         <= 1'b0;
            frame_done       <= 1'b0;
            beat_cnt         <= '0;
        end else begin
            if (axis_clear) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_state <= w_state_next;

            // Flags are derived from the next count so they never lag it.
            fifo_full        <= (w_count_next == DEPTH_C);
            fifo_almost_full <= ((DEPTH_C - w_count_next) <= MARGIN_C);
            fifo_empty       <= (w_count_next == '0);

            if (axis_clear) begin
                overflow <= 1'b0;
            end else if (w_drop) begin
                overflow <= 1'b1;
            end

            if (w_pop) begin
                {M_AXIS_TLAST, M_AXIS_TDATA} <= w_head;
            end

            frame_done <= w_handshake && M_AXIS_TLAST;
            if (w_handshake) begin
                if (M_AXIS_TLAST) begin
                    beat_cnt <= '0;
                end else if (beat_cnt != 16'hFFFF) begin
                    beat_cnt <= beat_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_m_axis_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_m_axis_tx_fifo
//   Directed bench for m_axis_tx_fifo. Expected beats are queued when pushed
//   and compared as they leave the bus; status outputs are checked against
//   constants at chosen points.
// ---------------------------------------------------------------------------
module tb_m_axis_tx_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        axis_en;
    logic        axis_clear;
    logic        tvalid;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tlast;
    logic        tready;
    logic        fifo_full;
    logic        fifo_almost_full;
    logic        fifo_empty;
    logic        overflow;
    logic        frame_done;
    logic [15:0] beat_cnt;

    int          total  = 0;
    int          bad    = 0;
    int          frames = 0;
    logic [32:0] sb[$];
    bit          prev_stall = 1'b0;
    logic [32:0] prev_beat  = '0;

    m_axis_tx_fifo dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_last          (in_last),
        .axis_en          (axis_en),
        .axis_clear       (axis_clear),
        .M_AXIS_TVALID    (tvalid),
        .M_AXIS_TDATA     (tdata),
        .M_AXIS_TSTRB     (tstrb),
        .M_AXIS_TLAST     (tlast),
        .M_AXIS_TREADY    (tready),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .fifo_empty       (fifo_empty),
        .overflow         (overflow),
        .frame_done       (frame_done),
        .beat_cnt         (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic l, input bit kept);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        if (kept) sb.push_back({l, d});
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(input int budget, input bit toggle);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            if (toggle) tready = ~tready;
            tick();
            n++;
        end
        check("drain_left", 64'(sb.size()), 64'd0);
    endtask

    // Output monitor: scoreboard compare on every handshake, plus stability of
    // a stalled beat, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                check("hold_valid", 64'(tvalid), 64'd1);
                check("hold_beat", 64'({tlast, tdata}), 64'(prev_beat));
            end
            if (tvalid && tready) begin
                total++;
                assert (sb.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_beat observed=%0h expected=none", {tlast, tdata});
                end
                if (sb.size() != 0) begin
                    check("beat", 64'({tlast, tdata}), 64'(sb.pop_front()));
                end
            end
            if (frame_done) frames++;
        end
        prev_stall = !rst && tvalid && !tready;
        prev_beat  = {tlast, tdata};
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        axis_en    = 1'b0;
        axis_clear = 1'b0;
        tready     = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_tdata", 64'(tdata), 64'd0);
        check("rst_tlast", 64'(tlast), 64'd0);
        check("rst_empty", 64'(fifo_empty), 64'd1);
        check("rst_full", 64'(fifo_full), 64'd0);
        check("rst_afull", 64'(fifo_almost_full), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_fdone", 64'(frame_done), 64'd0);
        check("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        check("tstrb", 64'(tstrb), 64'hF);
        rst = 1'b0;
        tick();

        // Basic frame: 2-cycle latency, back-to-back beats
        axis_en = 1'b1;
        tready  = 1'b1;
        push(32'h11, 1'b0, 1'b1);
        check("lat_edge1_tvalid", 64'(tvalid), 64'd0);
        push(32'h12, 1'b0, 1'b1);
        check("lat_edge2_tvalid", 64'(tvalid), 64'd1);
        check("lat_edge2_tdata", 64'(tdata), 64'h11);
        push(32'h13, 1'b0, 1'b1);
        push(32'h14, 1'b1, 1'b1);
        drain(20, 1'b0);
        tick();
        tick();
        check("t1_frames", 64'(frames), 64'd1);
        check("t1_beat_cnt", 64'(beat_cnt), 64'd0);
        check("t1_empty", 64'(fifo_empty), 64'd1);

        // Fill with backpressure, overflow on the dropped word
        tready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            push(32'h100 + 32'(i), (i == 16), (i < 17));
            if (i == 13) check("fill13_afull", 64'(fifo_almost_full), 64'd0);
            if (i == 14) check("fill14_afull", 64'(fifo_almost_full), 64'd1);
            if (i == 15) check("fill15_full", 64'(fifo_full), 64'd0);
            if (i == 16) check("fill16_full", 64'(fifo_full), 64'd1);
            if (i == 16) check("fill16_ovf", 64'(overflow), 64'd0);
            if (i == 17) check("fill17_ovf", 64'(overflow), 64'd1);
        end
        tready = 1'b1;
        drain(60, 1'b0);
        tick();
        check("t2_ovf_sticky", 64'(overflow), 64'd1);
        check("t2_empty", 64'(fifo_empty), 64'd1);
        check("t2_frames", 64'(frames), 64'd2);

        // Toggling TREADY while streaming
        for (int i = 0; i < 8; i++) begin
            tready = (i % 2 == 0);
            push(32'hA0 + 32'(i), (i == 7), 1'b1);
        end
        drain(60, 1'b1);
        tready = 1'b1;
        tick();
        tick();
        check("t3_frames", 64'(frames), 64'd3);

        // axis_en gating
        axis_en = 1'b0;
        push(32'h200, 1'b0, 1'b1);
        push(32'h201, 1'b0, 1'b1);
        push(32'h202, 1'b1, 1'b1);
        tick();
        check("en_off_tvalid", 64'(tvalid), 64'd0);
        check("en_off_empty", 64'(fifo_empty), 64'd0);
        tready  = 1'b0;
        axis_en = 1'b1;
        tick();
        check("en_on_tvalid", 64'(tvalid), 64'd1);
        check("en_on_tdata", 64'(tdata), 64'h200);
        axis_en = 1'b0;
        tick();
        tick();
        check("en_drop_tvalid", 64'(tvalid), 64'd1);
        tready = 1'b1;
        tick();
        check("en_drop_after_hs", 64'(tvalid), 64'd0);
        check("en_drop_left", 64'(sb.size()), 64'd2);
        axis_en = 1'b1;
        drain(20, 1'b0);
        tick();
        tick();
        check("t4_frames", 64'(frames), 64'd4);

        // axis_clear with 5 queued and one pending beat
        tready = 1'b0;
        push(32'h300, 1'b1, 1'b1);
        for (int i = 1; i < 6; i++) push(32'h300 + 32'(i), 1'b0, 1'b1);
        check("pre_clr_ovf", 64'(overflow), 64'd1);
        check("pre_clr_tdata", 64'(tdata), 64'h300);
        axis_clear = 1'b1;
        tick();
        axis_clear = 1'b0;
        while (sb.size() > 1) void'(sb.pop_back());
        check("clr_empty", 64'(fifo_empty), 64'd1);
        check("clr_full", 64'(fifo_full), 64'd0);
        check("clr_ovf", 64'(overflow), 64'd0);
        check("clr_tvalid", 64'(tvalid), 64'd1);
        tready = 1'b1;
        drain(10, 1'b0);
        tick();
        tick();
        tick();
        check("clr_tvalid_idle", 64'(tvalid), 64'd0);
        check("t5_frames", 64'(frames), 64'd5);

        // Reset while a beat is pending
        push(32'h400, 1'b0, 1'b1);
        push(32'h401, 1'b0, 1'b1);
        drain(10, 1'b0);
        tick();
        check("pre_rst_beat_cnt", 64'(beat_cnt), 64'd2);
        tready = 1'b0;
        push(32'h402, 1'b0, 1'b1);
        tick();
        check("pre_rst_tvalid", 64'(tvalid), 64'd1);
        rst = 1'b1;
        sb.delete();
        tick();
        check("mid_rst_tvalid", 64'(tvalid), 64'd0);
        check("mid_rst_tdata", 64'(tdata), 64'd0);
        check("mid_rst_empty", 64'(fifo_empty), 64'd1);
        check("mid_rst_beat_cnt", 64'(beat_cnt), 64'd0);
        rst    = 1'b0;
        tready = 1'b1;
        tick();
        push(32'h500, 1'b0, 1'b1);
        drain(10, 1'b0);
        tick();
        check("post_rst_beat_cnt", 64'(beat_cnt), 64'd1);
        push(32'h501, 1'b1, 1'b1);
        drain(10, 1'b0);
        tick();
        tick();
        check("post_rst_beat_cnt_end", 64'(beat_cnt), 64'd0);
        check("t6_frames", 64'(frames), 64'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
